cr_huf_comp_st_drain: RTL and testbench
=======================================

CR_HUF_COMP_ST_DRAIN -- requirements
Module: cr_huf_comp_st_drain

Interface
REQ-001 SHALL have parameter MAX_SYMBOL_TABLE_DEPTH, default 584, symbol-table entry count.
REQ-002 SHALL have parameter SYMB_WIDTH, default 5, width of one table symbol.
REQ-003 SHALL have parameter PTR_WIDTH, default 10, equal to ceil(log2(MAX_SYMBOL_TABLE_DEPTH+1)).
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low. Ports: clk input 1 (clock); rst_n input 1 (async active-low reset).
REQ-005 sym_buf_full  input  1  queue holds a complete table.
REQ-006 sym_buf_wr_ptr  input  PTR_WIDTH  number of entries to scan.
REQ-007 sym_buf_val  input  DEPTH  per-entry valid.
REQ-008 sym_buf_symbol  input  DEPTH x SYMB_WIDTH  per-entry symbol.
REQ-009 sym_buf_extra  input  DEPTH x 8  per-entry extra bits.
REQ-010 sym_buf_extra_length  input  DEPTH x 4  per-entry extra bit count.
REQ-011 st_seq_id  input  8  table sequence id.
REQ-012 st_build_error  input  1  table build failed.
REQ-013 sa_sym_rdy  input  1  downstream accepts symbol.
REQ-014 sa_sym_val  output  1  symbol valid.
REQ-015 sa_sym / sa_extra / sa_extra_len  output  SYMB_WIDTH / 8 / 4  emitted entry fields.
REQ-016 sa_tbl_done  output  1  one-cycle end-of-table pulse.
REQ-017 sa_tbl_err / sa_tbl_seq_id / sa_tbl_xtr_bits  output  1 / 8 / 14  table status, valid with sa_tbl_done.
REQ-018 sa_st_read_done  output  1  one-cycle release pulse to the symbol-table queue.

Function
REQ-019 FSM states SHALL be IDLE, DRAIN, DONE, WAIT_CLR.
REQ-020 IDLE: on sym_buf_full=1, capture st_seq_id and st_build_error, clear idx and xtr_bits, and go to DONE if st_build_error=1 or sym_buf_wr_ptr=0, else go to DRAIN.
REQ-021 Scan limit SHALL be min(sym_buf_wr_ptr, MAX_SYMBOL_TABLE_DEPTH), latched in IDLE.
REQ-022 DRAIN, output slot empty or accepted (sa_sym_val=0 or sa_sym_rdy=1):
- idx SHALL advance by 1.
- If sym_buf_val[idx]=1, load sa_sym/sa_extra/sa_extra_len from entry idx, set sa_sym_val=1, and add the extra_len to xtr_bits.
- If sym_buf_val[idx]=0, skip the entry with no emission (one cycle).
REQ-023 When sa_sym_val=1 and sa_sym_rdy=0, sa_sym_val, sa_sym, sa_extra and sa_extra_len SHALL hold stable and idx SHALL not advance.
REQ-024 sa_sym_val SHALL clear on acceptance when no new entry loads that cycle.
REQ-025 DRAIN to DONE SHALL occur when idx reaches the limit and the output slot is empty or being accepted.
REQ-026 DONE (one cycle):
- sa_tbl_done=1 and sa_st_read_done=1.
- sa_tbl_err = latched error.
- sa_tbl_seq_id = latched id.
- sa_tbl_xtr_bits = sum of emitted extra_len, 14 bits, no overflow (584 x 15 < 16384).
- Next state WAIT_CLR.
REQ-027 WAIT_CLR SHALL return to IDLE when sym_buf_full=0, preventing retrigger on the stale full flag.
REQ-028 No symbol SHALL be emitted for a table with st_build_error=1.
REQ-029 sym_buf_* inputs SHALL be sampled only in DRAIN; sym_buf_full dropping in DRAIN SHALL be ignored.
REQ-030 Latency SHALL be: sym_buf_full rise to first sa_sym_val = 2 cycles when entry 0 is valid; +1 cycle per skipped entry.

Reset
REQ-031 On rst_n=0, all outputs SHALL be 0, FSM SHALL be IDLE, and idx and xtr_bits SHALL be 0, asynchronously.
REQ-032 Reset mid-DRAIN SHALL abandon the table with no sa_st_read_done; after release, a still-high sym_buf_full SHALL restart the drain from entry 0.

Verification
REQ-033 Table: wr_ptr=3, all valid, extra_len 2/0/5, rdy=1 -> 3 symbols on consecutive cycles; then sa_tbl_done with xtr_bits=7; one sa_st_read_done pulse.
REQ-034 wr_ptr=4, val=1,0,0,1 -> 2 symbols, second 3 cycles after first; sa_tbl_done follows.
REQ-035 rdy held 0 for 5 cycles mid-table -> output fields stable; no symbol lost or duplicated.
REQ-036 st_build_error=1, wr_ptr=10 -> zero symbols; sa_tbl_done with sa_tbl_err=1; sa_st_read_done 2 cycles after full.
REQ-037 wr_ptr=0 -> sa_tbl_done with xtr_bits=0; full held high 3 cycles after read_done -> no second done.
REQ-038 wr_ptr=584, all valid, extra_len=15 -> 584 symbols; xtr_bits=8760. Reset asserted at symbol 100 -> outputs 0 immediately.

Source files
------------

// File: rtl/cr_huf_comp_st_drain.sv
// Drains a completed Huffman symbol table to the downstream symbol consumer,
// skipping invalid entries, then reports table status and releases the queue.
module cr_huf_comp_st_drain #(
    parameter int unsigned MAX_SYMBOL_TABLE_DEPTH = 584,
    parameter int unsigned SYMB_WIDTH             = 5,
    parameter int unsigned PTR_WIDTH              = 10
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   sym_buf_full,
    input  logic [PTR_WIDTH-1:0]                                   sym_buf_wr_ptr,
    input  logic [MAX_SYMBOL_TABLE_DEPTH-1:0]                      sym_buf_val,
    input  logic [MAX_SYMBOL_TABLE_DEPTH-1:0][SYMB_WIDTH-1:0]      sym_buf_symbol,
    input  logic [MAX_SYMBOL_TABLE_DEPTH-1:0][7:0]                 sym_buf_extra,
    input  logic [MAX_SYMBOL_TABLE_DEPTH-1:0][3:0]                 sym_buf_extra_length,
    input  logic [7:0]                                             st_seq_id,
    input  logic                                                   st_build_error,
    input  logic                                                   sa_sym_rdy,
    output logic                                                   sa_sym_val,
    output logic [SYMB_WIDTH-1:0]                                  sa_sym,
    output logic [7:0]                                             sa_extra,
    output logic [3:0]                                             sa_extra_len,
    output logic                                                   sa_tbl_done,
    output logic                                                   sa_tbl_err,
    output logic [7:0]                                             sa_tbl_seq_id,
    output logic [13:0]                                            sa_tbl_xtr_bits,
    output logic                                                   sa_st_read_done
);

    localparam int unsigned DEPTH = MAX_SYMBOL_TABLE_DEPTH;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned XTR_W = 14;
    localparam logic [PTR_WIDTH-1:0] DEPTH_PTR = PTR_WIDTH'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_DONE     = 2'd2,
        ST_WAIT_CLR = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [PTR_WIDTH-1:0]  idx_q, idx_d;
    logic [PTR_WIDTH-1:0]  limit_q, limit_d;
    logic [XTR_W-1:0]      xtr_q, xtr_d;
    logic                  err_q, err_d;
    logic [7:0]            seq_q, seq_d;

    logic                  sym_val_q, sym_val_d;
    logic [SYMB_WIDTH-1:0] sym_q, sym_d;
    logic [7:0]            extra_q, extra_d;
    logic [3:0]            extra_len_q, extra_len_d;
    logic                  tbl_done_q, tbl_done_d;
    logic                  tbl_err_q, tbl_err_d;
    logic [7:0]            tbl_seq_q, tbl_seq_d;
    logic [XTR_W-1:0]      tbl_xtr_q, tbl_xtr_d;
    logic                  read_done_q, read_done_d;

    logic                  slot_free_c;
    logic                  at_limit_c;
    logic [IDX_W-1:0]      rd_idx_c;
    logic                  rd_val_c;
    logic [SYMB_WIDTH-1:0] rd_sym_c;
    logic [7:0]            rd_extra_c;
    logic [3:0]            rd_len_c;

    // Current table entry and output-slot handshake status
    assign slot_free_c = !sym_val_q || sa_sym_rdy;
    assign at_limit_c  = (idx_q >= limit_q);
    assign rd_idx_c    = IDX_W'(idx_q);
    assign rd_val_c    = sym_buf_val[rd_idx_c];
    assign rd_sym_c    = sym_buf_symbol[rd_idx_c];
    assign rd_extra_c  = sym_buf_extra[rd_idx_c];
    assign rd_len_c    = sym_buf_extra_length[rd_idx_c];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (sym_buf_full) begin
                    if (st_build_error || (sym_buf_wr_ptr == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (slot_free_c && at_limit_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                if (!sym_buf_full) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        idx_d       = idx_q;
        limit_d     = limit_q;
        xtr_d       = xtr_q;
        err_d       = err_q;
        seq_d       = seq_q;
        sym_val_d   = sym_val_q;
        sym_d       = sym_q;
        extra_d     = extra_q;
        extra_len_d = extra_len_q;
        tbl_done_d  = 1'b0;
        tbl_err_d   = 1'b0;
        tbl_seq_d   = '0;
        tbl_xtr_d   = '0;
        read_done_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (sym_buf_full) begin
                    seq_d   = st_seq_id;
                    err_d   = st_build_error;
                    idx_d   = '0;
                    xtr_d   = '0;
                    limit_d = (sym_buf_wr_ptr > DEPTH_PTR) ? DEPTH_PTR : sym_buf_wr_ptr;
                end
            end
            ST_DRAIN: begin
                // Advance only when the output slot is empty or being taken
                if (slot_free_c) begin
                    if (at_limit_c) begin
                        sym_val_d = 1'b0;
                    end else begin
                        idx_d = idx_q + PTR_WIDTH'(1);
                        if (rd_val_c) begin
                            sym_val_d   = 1'b1;
                            sym_d       = rd_sym_c;
                            extra_d     = rd_extra_c;
                            extra_len_d = rd_len_c;
                            xtr_d       = xtr_q + XTR_W'(rd_len_c);
                        end else begin
                            sym_val_d = 1'b0;
                        end
                    end
                end
            end
            ST_DONE: begin
                tbl_done_d  = 1'b1;
                read_done_d = 1'b1;
                tbl_err_d   = err_q;
                tbl_seq_d   = seq_q;
                tbl_xtr_d   = xtr_q;
            end
            ST_WAIT_CLR: begin
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            limit_q     <= '0;
            xtr_q       <= '0;
            err_q       <= 1'b0;
            seq_q       <= '0;
            sym_val_q   <= 1'b0;
            sym_q       <= '0;
            extra_q     <= '0;
            extra_len_q <= '0;
            tbl_done_q  <= 1'b0;
            tbl_err_q   <= 1'b0;
            tbl_seq_q   <= '0;
            tbl_xtr_q   <= '0;
            read_done_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            limit_q     <= limit_d;
            xtr_q       <= xtr_d;
            err_q       <= err_d;
            seq_q       <= seq_d;
            sym_val_q   <= sym_val_d;
            sym_q       <= sym_d;
            extra_q     <= extra_d;
            extra_len_q <= extra_len_d;
            tbl_done_q  <= tbl_done_d;
            tbl_err_q   <= tbl_err_d;
            tbl_seq_q   <= tbl_seq_d;
            tbl_xtr_q   <= tbl_xtr_d;
            read_done_q <= read_done_d;
        end
    end

    assign sa_sym_val      = sym_val_q;
    assign sa_sym          = sym_q;
    assign sa_extra        = extra_q;
    assign sa_extra_len    = extra_len_q;
    assign sa_tbl_done     = tbl_done_q;
    assign sa_tbl_err      = tbl_err_q;
    assign sa_tbl_seq_id   = tbl_seq_q;
    assign sa_tbl_xtr_bits = tbl_xtr_q;
    assign sa_st_read_done = read_done_q;

endmodule

// File: tb/tb_cr_huf_comp_st_drain.sv
// Randomized self-checking bench for the symbol-table drain block.
module tb_cr_huf_comp_st_drain;

    localparam int unsigned DEPTH = 584;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        sym_buf_full = 1'b0;
    logic [9:0]                  sym_buf_wr_ptr = '0;
    logic [DEPTH-1:0]            sym_buf_val = '0;
    logic [DEPTH-1:0][4:0]       sym_buf_symbol = '0;
    logic [DEPTH-1:0][7:0]       sym_buf_extra = '0;
    logic [DEPTH-1:0][3:0]       sym_buf_extra_length = '0;
    logic [7:0]                  st_seq_id = '0;
    logic                        st_build_error = 1'b0;
    logic                        sa_sym_rdy = 1'b0;
    logic                        sa_sym_val;
    logic [4:0]                  sa_sym;
    logic [7:0]                  sa_extra;
    logic [3:0]                  sa_extra_len;
    logic                        sa_tbl_done;
    logic                        sa_tbl_err;
    logic [7:0]                  sa_tbl_seq_id;
    logic [13:0]                 sa_tbl_xtr_bits;
    logic                        sa_st_read_done;

    cr_huf_comp_st_drain dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .sym_buf_full         (sym_buf_full),
        .sym_buf_wr_ptr       (sym_buf_wr_ptr),
        .sym_buf_val          (sym_buf_val),
        .sym_buf_symbol       (sym_buf_symbol),
        .sym_buf_extra        (sym_buf_extra),
        .sym_buf_extra_length (sym_buf_extra_length),
        .st_seq_id            (st_seq_id),
        .st_build_error       (st_build_error),
        .sa_sym_rdy           (sa_sym_rdy),
        .sa_sym_val           (sa_sym_val),
        .sa_sym               (sa_sym),
        .sa_extra             (sa_extra),
        .sa_extra_len         (sa_extra_len),
        .sa_tbl_done          (sa_tbl_done),
        .sa_tbl_err           (sa_tbl_err),
        .sa_tbl_seq_id        (sa_tbl_seq_id),
        .sa_tbl_xtr_bits      (sa_tbl_xtr_bits),
        .sa_st_read_done      (sa_st_read_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] s;
        logic [7:0] e;
        logic [3:0] l;
    } sym_t;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         t0 = 0;
    int         acc_cnt = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         rd_cnt = 0;
    int         sym_cyc_q[$];
    sym_t       exp_q[$];
    bit         exp_active = 1'b0;
    logic       exp_err = 1'b0;
    logic [7:0] exp_seq = '0;
    logic [13:0] exp_xtr = '0;
    logic [13:0] last_xtr = '0;
    logic       last_err = 1'b0;
    bit         hold_v = 1'b0;
    sym_t       hold_s;
    sym_t       pop_s;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: every cycle, outputs against the expected-symbol queue
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", 64'({sa_sym_val, sa_sym, sa_extra, sa_extra_len, sa_tbl_done,
                 sa_tbl_err, sa_tbl_seq_id, sa_tbl_xtr_bits, sa_st_read_done}), 64'd0);
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("stall_val", 64'(sa_sym_val), 64'd1);
                chk("stall_fields", 64'({sa_sym, sa_extra, sa_extra_len}), 64'(hold_s));
            end
            hold_v = sa_sym_val && !sa_sym_rdy;
            hold_s = {sa_sym, sa_extra, sa_extra_len};
            if (sa_sym_val && sa_sym_rdy) begin
                acc_cnt++;
                sym_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_sym: got sym %0d, none expected (cycle %0d)", sa_sym, cyc);
                end else begin
                    pop_s = exp_q.pop_front();
                    chk("sym_fields", 64'({sa_sym, sa_extra, sa_extra_len}), 64'(pop_s));
                end
            end
            chk("read_done_with_tbl_done", 64'(sa_st_read_done), 64'(sa_tbl_done));
            if (sa_st_read_done) rd_cnt++;
            if (sa_tbl_done) begin
                done_cnt++;
                done_cyc = cyc;
                last_xtr = sa_tbl_xtr_bits;
                last_err = sa_tbl_err;
                if (!exp_active) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done, none expected (cycle %0d)", cyc);
                end else begin
                    chk("tbl_err", 64'(sa_tbl_err), 64'(exp_err));
                    chk("tbl_seq_id", 64'(sa_tbl_seq_id), 64'(exp_seq));
                    chk("tbl_xtr_bits", 64'(sa_tbl_xtr_bits), 64'(exp_xtr));
                    chk("syms_left_at_done", 64'(exp_q.size()), 64'd0);
                    exp_active = 1'b0;
                end
            end
        end
    end

    // Reference: emitted list is every valid entry below min(wr_ptr, depth) unless errored
    task automatic build_model(input int unsigned wp, input bit err, input logic [7:0] seq);
        int unsigned lim;
        int unsigned sum;
        logic [9:0]  k10;
        sym_t        s;
        exp_q.delete();
        sym_cyc_q.delete();
        acc_cnt = 0;
        sum = 0;
        lim = (wp > DEPTH) ? DEPTH : wp;
        if (!err) begin
            for (int unsigned k = 0; k < lim; k++) begin
                k10 = 10'(k);
                if (sym_buf_val[k10]) begin
                    s.s = sym_buf_symbol[k10];
                    s.e = sym_buf_extra[k10];
                    s.l = sym_buf_extra_length[k10];
                    exp_q.push_back(s);
                    sum += sym_buf_extra_length[k10];
                end
            end
        end
        exp_xtr = 14'(sum);
        exp_err = err;
        exp_seq = seq;
        exp_active = 1'b1;
    endtask

    task automatic start_table(input int unsigned wp, input bit err, input logic [7:0] seq);
        build_model(wp, err, seq);
        sym_buf_wr_ptr = 10'(wp);
        st_build_error = err;
        st_seq_id = seq;
        sym_buf_full = 1'b1;
        t0 = cyc;
    endtask

    // mode 0: always ready; 1: random ready; 2: five-cycle stall after two symbols
    task automatic wait_done(input int mode, input int budget);
        int d0;
        int n;
        int stall;
        d0 = done_cnt;
        n = 0;
        stall = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            #2;
            if (mode == 1) sa_sym_rdy = ($urandom_range(0, 3) != 0);
            else if (mode == 2 && acc_cnt >= 2 && stall < 5) begin
                sa_sym_rdy = 1'b0;
                stall++;
            end else sa_sym_rdy = 1'b1;
            n++;
        end
        if (done_cnt == d0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done within %0d cycles", budget);
        end
    endtask

    task automatic end_table(input int hold);
        repeat (hold) begin
            @(posedge clk);
            #2;
        end
        sym_buf_full = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic fill_rand();
        for (int unsigned k = 0; k < DEPTH; k++) begin
            sym_buf_val[10'(k)]          = 1'($urandom_range(0, 1));
            sym_buf_symbol[10'(k)]       = 5'($urandom);
            sym_buf_extra[10'(k)]        = 8'($urandom);
            sym_buf_extra_length[10'(k)] = 4'($urandom);
        end
    endtask

    initial begin
        int rd0;
        int d0;
        int n;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        sa_sym_rdy = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #2;
        end

        // Three valid entries, extra lengths 2/0/5
        fill_rand();
        sym_buf_val[2:0] = 3'b111;
        sym_buf_extra_length[0] = 4'd2;
        sym_buf_extra_length[1] = 4'd0;
        sym_buf_extra_length[2] = 4'd5;
        rd0 = rd_cnt;
        start_table(3, 1'b0, 8'h11);
        wait_done(0, 100);
        end_table(1);
        chk("t1_sym_count", 64'(sym_cyc_q.size()), 64'd3);
        if (sym_cyc_q.size() == 3) begin
            chk("t1_first_latency", 64'(sym_cyc_q[0] - t0), 64'd2);
            chk("t1_consec_1", 64'(sym_cyc_q[1] - sym_cyc_q[0]), 64'd1);
            chk("t1_consec_2", 64'(sym_cyc_q[2] - sym_cyc_q[1]), 64'd1);
        end
        chk("t1_xtr_literal", 64'(last_xtr), 64'd7);
        chk("t1_read_done_pulses", 64'(rd_cnt - rd0), 64'd1);

        // Sparse table: valid 1,0,0,1
        fill_rand();
        sym_buf_val[3:0] = 4'b1001;
        start_table(4, 1'b0, 8'h22);
        wait_done(0, 100);
        end_table(1);
        chk("t2_sym_count", 64'(sym_cyc_q.size()), 64'd2);
        if (sym_cyc_q.size() == 2) begin
            chk("t2_gap", 64'(sym_cyc_q[1] - sym_cyc_q[0]), 64'd3);
        end

        // Downstream stall of five cycles mid-table
        fill_rand();
        sym_buf_val[7:0] = 8'hff;
        start_table(8, 1'b0, 8'h33);
        wait_done(2, 200);
        end_table(1);
        chk("t3_sym_count", 64'(acc_cnt), 64'd8);

        // Build error: nothing emitted, done two cycles after full
        fill_rand();
        start_table(10, 1'b1, 8'h44);
        wait_done(1, 100);
        end_table(1);
        chk("t4_sym_count", 64'(acc_cnt), 64'd0);
        chk("t4_done_latency", 64'(done_cyc - t0), 64'd2);
        chk("t4_err_literal", 64'(last_err), 64'd1);

        // Empty table, full held past done
        fill_rand();
        start_table(0, 1'b0, 8'h55);
        wait_done(0, 100);
        d0 = done_cnt;
        end_table(3);
        chk("t5_no_second_done", 64'(done_cnt), 64'(d0));
        chk("t5_xtr_literal", 64'(last_xtr), 64'd0);

        // Random tables with random backpressure
        for (int t = 0; t < 8; t++) begin
            fill_rand();
            start_table((t == 3) ? 700 : $urandom_range(1, 60), ($urandom_range(0, 4) == 0), 8'($urandom));
            wait_done(1, 3000);
            end_table($urandom_range(0, 3));
        end

        // Full-depth table, all valid, extra length 15
        for (int unsigned k = 0; k < DEPTH; k++) begin
            sym_buf_val[10'(k)] = 1'b1;
            sym_buf_extra_length[10'(k)] = 4'd15;
        end
        start_table(584, 1'b0, 8'h66);
        wait_done(0, 1000);
        end_table(1);
        chk("t6_sym_count", 64'(acc_cnt), 64'd584);
        chk("t6_xtr_literal", 64'(last_xtr), 64'd8760);

        // Reset at symbol 100 abandons the table; still-full queue restarts from entry 0
        rd0 = rd_cnt;
        start_table(584, 1'b0, 8'h77);
        n = 0;
        while (acc_cnt < 100 && n < 400) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("t7_reached_sym_100", 64'(acc_cnt >= 100), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t7_async_reset_outputs", 64'({sa_sym_val, sa_sym, sa_extra, sa_extra_len, sa_tbl_done,
             sa_tbl_err, sa_tbl_seq_id, sa_tbl_xtr_bits, sa_st_read_done}), 64'd0);
        chk("t7_no_release_on_abandon", 64'(rd_cnt - rd0), 64'd0);
        build_model(584, 1'b0, 8'h77);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_done(0, 1000);
        end_table(1);
        chk("t7_restart_sym_count", 64'(acc_cnt), 64'd584);
        chk("t7_restart_xtr", 64'(last_xtr), 64'd8760);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
